// File: rtl/fcb_vlp_pkg.sv
// Shared types and parameter limits for the multi-channel VLP pin sequencer.
package fcb_vlp_pkg;

  localparam int NUM_CH_MIN     = 1;
  localparam int NUM_CH_MAX     = 8;
  localparam int FILT_DEPTH_MIN = 2;
  localparam int FILT_DEPTH_MAX = 16;
  localparam int SETTLE_CYC_MIN = 1;
  localparam int SETTLE_CYC_MAX = 15;

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    ARM      = 4'd1,
    AWAKE    = 4'd2,
    ENT_REQ  = 4'd3,
    ENT_SET  = 4'd4,
    ENT_WAIT = 4'd5,
    ASLEEP   = 4'd6,
    EXT_REQ  = 4'd7,
    EXT_SET  = 4'd8,
    EXT_WAIT = 4'd9
  } vlp_seq_state_e;

endpackage

// File: rtl/fcb_vlp_pin_seq_chan.sv
// One VLP channel: pin glitch filter, enter/wake sequencer, settle and
// timeout counters, sticky timeout error.
//
// state    | meaning
// IDLE     | run low, channel parked
// ARM      | waiting for the filtered pin to settle to a known level
// AWAKE    | channel awake, watching for a stable VLP request
// ENT_REQ  | one-cycle set pulse to the VLP-enable bit
// ENT_SET  | fixed settle time before the enable bit is sampled
// ENT_WAIT | waiting for the PMU/CLP to clear the VLP-enable bit
// ASLEEP   | channel in VLP, watching for a stable wake request
// EXT_REQ  | one-cycle set pulse to the wake-up-enable bit
// EXT_SET  | fixed settle time before the wake bit is sampled
// EXT_WAIT | waiting for the PMU/CLP to clear the wake-up-enable bit
module fcb_vlp_chan
  import fcb_vlp_pkg::*;
#(
  parameter int FILT_DEPTH = 4,
  parameter int SETTLE_CYC = 3,
  parameter int TO_W       = 8
) (
  input  logic            fcb_sys_clk,
  input  logic            fcb_sys_rst_n,
  input  logic            run,
  input  logic            vlp_pin,
  input  logic            vlp_en_sta,
  input  logic            wu_en_sta,
  input  logic [TO_W-1:0] to_limit,
  input  logic            to_err_clr,
  output logic            set_vlp_en,
  output logic            set_wu_en,
  output logic            in_vlp,
  output logic            busy,
  output logic            to_err
);

  localparam int         SH_W      = FILT_DEPTH - 1;
  localparam logic [3:0] SETTLE_LD = 4'(SETTLE_CYC - 1);

  vlp_seq_state_e  state, nxt;
  logic [SH_W-1:0] filt_q;
  logic [3:0]      settle_cnt;
  logic [TO_W-1:0] to_cnt;
  logic            stb1, stb0;
  logic            to_fire, to_hit;
  logic            in_wait;

  assign stb1    = vlp_pin & (&filt_q);
  assign stb0    = ~vlp_pin & ~(|filt_q);
  assign in_wait = (state == ENT_WAIT) || (state == EXT_WAIT);
  assign to_fire = (to_limit != '0) && (to_cnt == to_limit - TO_W'(1));

  // Pin sample history; a pin level counts only once every flop agrees with it.
  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n)  filt_q <= '0;
    else if (!run)       filt_q <= '0;
    else                 filt_q <= SH_W'({filt_q, vlp_pin});
  end

  // State register.
  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n) state <= IDLE;
    else                state <= nxt;
  end

  // Settle down-counter, loaded during the set pulse, terminal count at 0.
  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n)                               settle_cnt <= '0;
    else if (!run)                                    settle_cnt <= '0;
    else if ((state == ENT_REQ) || (state == EXT_REQ)) settle_cnt <= SETTLE_LD;
    else if (settle_cnt != '0)                        settle_cnt <= settle_cnt - 4'd1;
  end

  // Handshake timeout counter; zero on WAIT entry, counts while WAIT persists.
  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n)                  to_cnt <= '0;
    else if (in_wait && (nxt == state))  to_cnt <= to_cnt + TO_W'(1);
    else                                 to_cnt <= '0;
  end

  // Sticky timeout error; a new timeout beats a coincident clear.
  always_ff @(posedge fcb_sys_clk or negedge fcb_sys_rst_n) begin
    if (!fcb_sys_rst_n)  to_err <= 1'b0;
    else if (to_hit)     to_err <= 1'b1;
    else if (to_err_clr) to_err <= 1'b0;
  end

  // Next-state logic; ack beats timeout in the WAIT states, run low forces IDLE.
  always_comb begin
    nxt    = state;
    to_hit = 1'b0;
    case (state)
      IDLE:     nxt = ARM;
      ARM: begin
        if (stb0)      nxt = AWAKE;
        else if (stb1) nxt = ENT_REQ;
      end
      AWAKE:    if (stb1) nxt = ENT_REQ;
      ENT_REQ:  nxt = ENT_SET;
      ENT_SET:  if (settle_cnt == '0) nxt = ENT_WAIT;
      ENT_WAIT: begin
        if (!vlp_en_sta) nxt = ASLEEP;
        else if (to_fire) begin
          nxt    = ARM;
          to_hit = 1'b1;
        end
      end
      ASLEEP:   if (stb0) nxt = EXT_REQ;
      EXT_REQ:  nxt = EXT_SET;
      EXT_SET:  if (settle_cnt == '0) nxt = EXT_WAIT;
      EXT_WAIT: begin
        if (!wu_en_sta) nxt = AWAKE;
        else if (to_fire) begin
          nxt    = ARM;
          to_hit = 1'b1;
        end
      end
      default:  nxt = IDLE;
    endcase
    if (!run) begin
      nxt    = IDLE;
      to_hit = 1'b0;
    end
  end

  assign set_vlp_en = (state == ENT_REQ);
  assign set_wu_en  = (state == EXT_REQ);
  assign in_vlp     = (state == ENT_REQ) || (state == ENT_SET) || (state == ENT_WAIT) ||
                      (state == ASLEEP)  || (state == EXT_REQ);
  assign busy       = (state == ENT_REQ) || (state == ENT_SET) || (state == ENT_WAIT) ||
                      (state == EXT_REQ) || (state == EXT_SET) || (state == EXT_WAIT);

endmodule

// File: rtl/fcb_vlp_pin_seq.sv
// Multi-channel VLP pin sequencer: one independent channel per pin, all
// gated by the shared run condition.
module fcb_vlp_pin_seq
  import fcb_vlp_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int FILT_DEPTH = 4,
  parameter int SETTLE_CYC = 3,
  parameter int TO_W       = 8
) (
  input  logic              fcb_sys_clk,
  input  logic              fcb_sys_rst_n,
  input  logic              ctl_en,
  input  logic              cfg_done,
  input  logic [NUM_CH-1:0] vlp_pin,
  input  logic [NUM_CH-1:0] vlp_en_sta,
  input  logic [NUM_CH-1:0] wu_en_sta,
  input  logic [TO_W-1:0]   to_limit,
  input  logic [NUM_CH-1:0] to_err_clr,
  output logic [NUM_CH-1:0] set_vlp_en,
  output logic [NUM_CH-1:0] set_wu_en,
  output logic [NUM_CH-1:0] in_vlp,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] to_err
);

  if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
    $error("fcb_vlp_pin_seq: NUM_CH out of range");
  end
  if (FILT_DEPTH < FILT_DEPTH_MIN || FILT_DEPTH > FILT_DEPTH_MAX) begin : g_bad_filt
    $error("fcb_vlp_pin_seq: FILT_DEPTH out of range");
  end
  if (SETTLE_CYC < SETTLE_CYC_MIN || SETTLE_CYC > SETTLE_CYC_MAX) begin : g_bad_settle
    $error("fcb_vlp_pin_seq: SETTLE_CYC out of range");
  end

  logic run;
  assign run = ctl_en & cfg_done;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    fcb_vlp_chan #(
      .FILT_DEPTH (FILT_DEPTH),
      .SETTLE_CYC (SETTLE_CYC),
      .TO_W       (TO_W)
    ) u_chan (
      .fcb_sys_clk   (fcb_sys_clk),
      .fcb_sys_rst_n (fcb_sys_rst_n),
      .run           (run),
      .vlp_pin       (vlp_pin[i]),
      .vlp_en_sta    (vlp_en_sta[i]),
      .wu_en_sta     (wu_en_sta[i]),
      .to_limit      (to_limit),
      .to_err_clr    (to_err_clr[i]),
      .set_vlp_en    (set_vlp_en[i]),
      .set_wu_en     (set_wu_en[i]),
      .in_vlp        (in_vlp[i]),
      .busy          (busy[i]),
      .to_err        (to_err[i])
    );
  end

endmodule

// File: tb/tb_fcb_vlp_pin_seq.sv
// Directed bench for fcb_vlp_pin_seq: expected set pulses go into a queue,
// a negedge monitor pops and compares them; status is checked inline.
module tb_fcb_vlp_pin_seq;

  localparam int NUM_CH     = 4;
  localparam int FILT_DEPTH = 4;
  localparam int SETTLE_CYC = 3;
  localparam int TO_W       = 8;

  logic              clk;
  logic              rst_n;
  logic              ctl_en;
  logic              cfg_done;
  logic [NUM_CH-1:0] vlp_pin;
  logic [NUM_CH-1:0] vlp_en_sta;
  logic [NUM_CH-1:0] wu_en_sta;
  logic [TO_W-1:0]   to_limit;
  logic [NUM_CH-1:0] to_err_clr;
  logic [NUM_CH-1:0] set_vlp_en;
  logic [NUM_CH-1:0] set_wu_en;
  logic [NUM_CH-1:0] in_vlp;
  logic [NUM_CH-1:0] busy;
  logic [NUM_CH-1:0] to_err;

  fcb_vlp_pin_seq #(
    .NUM_CH     (NUM_CH),
    .FILT_DEPTH (FILT_DEPTH),
    .SETTLE_CYC (SETTLE_CYC),
    .TO_W       (TO_W)
  ) dut (
    .fcb_sys_clk   (clk),
    .fcb_sys_rst_n (rst_n),
    .ctl_en        (ctl_en),
    .cfg_done      (cfg_done),
    .vlp_pin       (vlp_pin),
    .vlp_en_sta    (vlp_en_sta),
    .wu_en_sta     (wu_en_sta),
    .to_limit      (to_limit),
    .to_err_clr    (to_err_clr),
    .set_vlp_en    (set_vlp_en),
    .set_wu_en     (set_wu_en),
    .in_vlp        (in_vlp),
    .busy          (busy),
    .to_err        (to_err)
  );

  typedef struct {
    int               cyc;
    logic [NUM_CH-1:0] vlp;
    logic [NUM_CH-1:0] wu;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t mon_e;
  int     cyc   = 0;
  int     total = 0;
  int     bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every observed set pulse must match the next expected entry.
  always @(negedge clk) begin
    if (rst_n && ((|set_vlp_en) || (|set_wu_en))) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_pulse cyc=%0d vlp=%b wu=%b", cyc, set_vlp_en, set_wu_en);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_e.cyc != cyc || mon_e.vlp !== set_vlp_en || mon_e.wu !== set_wu_en) begin
          bad++;
          $display("FAIL pulse got cyc=%0d vlp=%b wu=%b, want cyc=%0d vlp=%b wu=%b",
                   cyc, set_vlp_en, set_wu_en, mon_e.cyc, mon_e.vlp, mon_e.wu);
        end
      end
    end
  end

  task automatic push(input int c, input logic [NUM_CH-1:0] v, input logic [NUM_CH-1:0] w);
    pulse_t e;
    e.cyc = c;
    e.vlp = v;
    e.wu  = w;
    exp_q.push_back(e);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, got, want);
    end
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk);
  endtask

  int b, c, g, h, t, u, v, r, w;

  initial begin
    rst_n      = 1'b0;
    ctl_en     = 1'b1;
    cfg_done   = 1'b1;
    vlp_pin    = '0;
    vlp_en_sta = '0;
    wu_en_sta  = '0;
    to_limit   = '0;
    to_err_clr = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {set_vlp_en, set_wu_en, in_vlp, busy, to_err}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Enter VLP on channel 0, ack after settle.
    b = cyc;
    vlp_pin[0] = 1'b1;
    push(b + 4, 4'b0001, 4'b0000);
    wait_to(b + 4);
    check("ent_req_in_vlp", in_vlp, 4'b0001);
    wait_to(b + 5);  vlp_en_sta[0] = 1'b1;
    wait_to(b + 9);
    check("ent_wait_busy", busy, 4'b0001);
    vlp_en_sta[0] = 1'b0;
    wait_to(b + 10);
    check("asleep_in_vlp", in_vlp, 4'b0001);
    check("asleep_busy", busy, 4'b0000);

    // Wake channel 0.
    wait_to(b + 11);
    c = cyc;
    vlp_pin[0] = 1'b0;
    push(c + 4, 4'b0000, 4'b0001);
    wait_to(c + 4);
    check("ext_req_in_vlp", in_vlp, 4'b0001);
    wait_to(c + 5);  wu_en_sta[0] = 1'b1;
    wait_to(c + 9);
    check("ext_wait_busy", busy, 4'b0001);
    check("ext_wait_in_vlp", in_vlp, 4'b0000);
    wu_en_sta[0] = 1'b0;
    wait_to(c + 10);
    check("awake_in_vlp", in_vlp, 4'b0000);
    check("awake_busy", busy, 4'b0000);

    // 3-cycle glitch: filtered out.
    wait_to(c + 12);
    g = cyc;
    vlp_pin[0] = 1'b1;
    wait_to(g + 3);  vlp_pin[0] = 1'b0;
    wait_to(g + 8);
    check("glitch3_in_vlp", in_vlp, 4'b0000);
    check("glitch3_busy", busy, 4'b0000);

    // 4-cycle glitch: one enter pulse; the bounce back is seen only once asleep.
    wait_to(g + 9);
    h = cyc;
    vlp_pin[0] = 1'b1;
    push(h + 4, 4'b0001, 4'b0000);
    wait_to(h + 4);  vlp_pin[0] = 1'b0;
    wait_to(h + 5);  vlp_en_sta[0] = 1'b1;
    wait_to(h + 9);  vlp_en_sta[0] = 1'b0;
    push(h + 11, 4'b0000, 4'b0001);
    wait_to(h + 10);
    check("glitch4_asleep", in_vlp, 4'b0001);
    wait_to(h + 12); wu_en_sta[0] = 1'b1;
    wait_to(h + 15); wu_en_sta[0] = 1'b0;
    wait_to(h + 16);
    check("glitch4_awake", {in_vlp, busy}, 8'h00);

    // Timeout: limit 10, ack never comes; retry times out with a coincident clear.
    wait_to(h + 17);
    t = cyc;
    to_limit = 8'd10;
    vlp_pin[0] = 1'b1;
    push(t + 4, 4'b0001, 4'b0000);
    wait_to(t + 5);  vlp_en_sta[0] = 1'b1;
    wait_to(t + 17);
    check("to_pre_err", to_err, 4'b0000);
    check("to_pre_busy", busy, 4'b0001);
    wait_to(t + 18);
    check("to_err_set", to_err, 4'b0001);
    check("to_arm_busy", busy, 4'b0000);
    check("to_arm_in_vlp", in_vlp, 4'b0000);
    push(t + 19, 4'b0001, 4'b0000);
    wait_to(t + 32); to_err_clr[0] = 1'b1;
    check("to2_pre_busy", busy, 4'b0001);
    wait_to(t + 33);
    to_err_clr[0] = 1'b0;
    check("to_clr_vs_set", to_err, 4'b0001);
    check("to2_arm_busy", busy, 4'b0000);
    vlp_pin[0]    = 1'b0;
    vlp_en_sta[0] = 1'b0;
    to_limit      = 8'd0;

    // Run drop during ENT_SET aborts; to_err retained.
    wait_to(t + 38);
    u = cyc;
    vlp_pin[0] = 1'b1;
    push(u + 4, 4'b0001, 4'b0000);
    wait_to(u + 5);
    check("runoff_pre_busy", busy, 4'b0001);
    ctl_en = 1'b0;
    wait_to(u + 6);
    check("runoff_in_vlp", in_vlp, 4'b0000);
    check("runoff_busy", busy, 4'b0000);
    check("runoff_to_err", to_err, 4'b0001);
    vlp_pin[0] = 1'b0;
    wait_to(u + 7);  ctl_en = 1'b1;

    // Async reset while in EXT_WAIT.
    wait_to(u + 10);
    v = cyc;
    vlp_pin[0] = 1'b1;
    push(v + 4, 4'b0001, 4'b0000);
    wait_to(v + 5);  vlp_en_sta[0] = 1'b1;
    wait_to(v + 8);  vlp_en_sta[0] = 1'b0;
    wait_to(v + 9);
    check("rst_pre_asleep", {in_vlp, busy}, 8'h10);
    vlp_pin[0] = 1'b0;
    push(v + 13, 4'b0000, 4'b0001);
    wait_to(v + 14); wu_en_sta[0] = 1'b1;
    wait_to(v + 18);
    check("rst_pre_ext_wait", {in_vlp, busy, to_err}, 12'h011);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outputs", {set_vlp_en, set_wu_en, in_vlp, busy, to_err}, 32'h0);
    wu_en_sta[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    r = cyc;

    // Channels 0 and 2 enter together; 1 and 3 stay awake.
    wait_to(r + 3);
    w = cyc;
    vlp_pin = 4'b0101;
    push(w + 4, 4'b0101, 4'b0000);
    wait_to(w + 5);
    check("multi_in_vlp", in_vlp, 4'b0101);
    check("multi_busy", busy, 4'b0101);
    wait_to(w + 8);

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL missing_pulses left=%0d want=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
